// File: rtl/lane_scheduler_if.sv
// Handshake bundle between the lane scheduler and its surroundings:
// arrival/departure events in, lane selection, phase flags and counts out.
interface lane_scheduler_if #(
  parameter int CNT_W = 4
);
  logic [3:0]         arrive;
  logic               depart;
  logic [1:0]         largest;
  logic               green;
  logic               yellow;
  logic [4*CNT_W-1:0] counts;

  modport master (
    output arrive, depart,
    input  largest, green, yellow, counts
  );

  modport slave (
    input  arrive, depart,
    output largest, green, yellow, counts
  );
endinterface

// File: rtl/lane_scheduler.sv
// Lane scheduler: per-approach car counters plus a GREEN/YELLOW phase
// sequencer that serves the approach with the most waiting cars.
//
// state  | meaning
// IDLE   | no cars waiting, lights dark
// SELECT | one-cycle gap, latch argmax lane into largest
// GREEN  | serve largest, bounded by GREEN_MIN..GREEN_MAX cycles
// YELLOW | fixed YELLOW_LEN cycles before reselecting
module lane_scheduler #(
  parameter int CNT_W      = 4,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 16,
  parameter int YELLOW_LEN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  lane_scheduler_if.slave   bus
);
  localparam int TMR_MAX = (GREEN_MAX > YELLOW_LEN) ? GREEN_MAX : YELLOW_LEN;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {IDLE, SELECT, GREEN, YELLOW} state_t;

  state_t             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [1:0]         largest_q;
  logic               green_q;
  logic               yellow_q;
  logic [CNT_W-1:0]   cnt_q [4];
  logic [CNT_W-1:0]   cnt_d [4];

  logic [1:0]         best_idx;
  logic [CNT_W-1:0]   best_cnt;
  logic [CNT_W-1:0]   cur_cnt;
  logic               rival;
  logic               any_waiting;
  logic               green_done;

  // Argmax over registered counts; strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx = 2'd0;
    best_cnt = cnt_q[0];
    for (int i = 1; i < 4; i++) begin
      if (cnt_q[i] > best_cnt) begin
        best_cnt = cnt_q[i];
        best_idx = 2'(i);
      end
    end
  end

  // Phase-end conditions for the currently served lane.
  always_comb begin
    cur_cnt     = cnt_q[largest_q];
    rival       = 1'b0;
    any_waiting = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != largest_q && cnt_q[i] > cur_cnt) rival = 1'b1;
      if (cnt_q[i] != '0) any_waiting = 1'b1;
    end
    green_done = (timer_q == TMR_W'(GREEN_MAX - 1)) ||
                 ((timer_q >= TMR_W'(GREEN_MIN - 1)) && ((cur_cnt == '0) || rival));
  end

  // Counter next-state: saturating increment, depart only on the served lane;
  // a same-cycle arrive and depart cancel even when the counter is full.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic dec_ok;
      dec_ok   = bus.depart && (state_q == GREEN) && (largest_q == 2'(i)) && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (bus.arrive[i] && dec_ok)        cnt_d[i] = cnt_q[i];
      else if (bus.arrive[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec_ok)                    cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  // Per-lane car counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Phase sequencer; green/yellow are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      largest_q <= 2'd0;
      green_q   <= 1'b0;
      yellow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_waiting) state_q <= SELECT;
        end
        SELECT: begin
          largest_q <= best_idx;
          timer_q   <= '0;
          state_q   <= GREEN;
          green_q   <= 1'b1;
        end
        GREEN: begin
          if (green_done) begin
            timer_q  <= '0;
            state_q  <= YELLOW;
            green_q  <= 1'b0;
            yellow_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        YELLOW: begin
          if (timer_q == TMR_W'(YELLOW_LEN - 1)) begin
            timer_q  <= '0;
            yellow_q <= 1'b0;
            state_q  <= any_waiting ? SELECT : IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output packing.
  always_comb begin
    bus.counts = '0;
    for (int i = 0; i < 4; i++) bus.counts[i*CNT_W +: CNT_W] = cnt_q[i];
    bus.largest = largest_q;
    bus.green   = green_q;
    bus.yellow  = yellow_q;
  end
endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler with hand-computed expectations.
module tb_lane_scheduler;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n;
  int   total;

  lane_scheduler_if #(.CNT_W(4)) bus ();

  lane_scheduler #(
    .CNT_W(4), .GREEN_MIN(4), .GREEN_MAX(16), .YELLOW_LEN(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.arrive = 4'b0;
    bus.depart = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Counts edges until the selected phase flag drops, applying arr for the
  // first arr_cycles of them; bounded so a stuck phase still terminates.
  task automatic run_phase(input bit yel, input logic [3:0] arr, input int arr_cycles,
                           output int cyc);
    cyc = 0;
    while ((yel ? bus.yellow : bus.green) && cyc < 64) begin
      bus.arrive = (cyc < arr_cycles) ? arr : 4'b0;
      tick();
      cyc++;
    end
    bus.arrive = 4'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.arrive = 4'b0;
    bus.depart = 1'b0;
    rst_n = 1'b0;

    // Reset values
    do_reset();
    chk("rst_largest", 32'(bus.largest), 32'd0);
    chk("rst_green",   32'(bus.green),   32'd0);
    chk("rst_yellow",  32'(bus.yellow),  32'd0);
    chk("rst_counts",  32'(bus.counts),  32'h0);

    // Single car on E, depart on first GREEN cycle
    bus.arrive = 4'b0010;
    tick();
    bus.arrive = 4'b0;
    chk("e_count1", 32'(bus.counts), 32'h0010);
    tick();
    chk("e_select_nogreen", 32'(bus.green), 32'd0);
    tick();
    chk("e_largest", 32'(bus.largest), 32'd1);
    chk("e_green",   32'(bus.green),   32'd1);
    bus.depart = 1'b1;
    tick();
    bus.depart = 1'b0;
    chk("e_count0", 32'(bus.counts), 32'h0);
    run_phase(1'b0, 4'b0, 0, n);
    total = n + 1;
    chk("e_green_len", 32'(total), 32'd4);
    chk("e_yellow_on", 32'(bus.yellow), 32'd1);
    run_phase(1'b1, 4'b0, 0, n);
    chk("e_yellow_len", 32'(n), 32'd2);
    tick();
    tick();
    chk("e_idle_green",   32'(bus.green),   32'd0);
    chk("e_idle_yellow",  32'(bus.yellow),  32'd0);
    chk("e_idle_largest", 32'(bus.largest), 32'd1);

    // Tie between S and W resolves to S, then async reset mid-GREEN
    do_reset();
    bus.arrive = 4'b1100;
    tick();
    tick();
    tick();
    bus.arrive = 4'b0;
    chk("tie_largest", 32'(bus.largest), 32'd2);
    chk("tie_green",   32'(bus.green),   32'd1);
    chk("tie_counts",  32'(bus.counts),  32'h3300);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_green",   32'(bus.green),   32'd0);
    chk("async_yellow",  32'(bus.yellow),  32'd0);
    chk("async_largest", 32'(bus.largest), 32'd0);
    chk("async_counts",  32'(bus.counts),  32'h0);

    // Max green on N with 15 cars and no departs
    do_reset();
    bus.arrive = 4'b0001;
    tick();
    tick();
    tick();
    chk("max_green_on", 32'(bus.green), 32'd1);
    run_phase(1'b0, 4'b0001, 12, n);
    chk("max_green_len", 32'(n), 32'd16);
    chk("max_counts",    32'(bus.counts), 32'h000F);
    chk("max_yellow_on", 32'(bus.yellow), 32'd1);
    run_phase(1'b1, 4'b0, 0, n);
    chk("max_yellow_len", 32'(n), 32'd2);
    chk("max_select_gap", 32'({bus.green, bus.yellow}), 32'd0);
    tick();
    chk("max_reselect_green",   32'(bus.green),   32'd1);
    chk("max_reselect_largest", 32'(bus.largest), 32'd0);

    // Preemption of N=2 by E after GREEN_MIN
    do_reset();
    bus.arrive = 4'b0001;
    tick();
    tick();
    bus.arrive = 4'b0;
    tick();
    chk("pre_n_green", 32'(bus.green), 32'd1);
    tick();
    tick();
    tick();
    bus.arrive = 4'b0010;
    tick();
    tick();
    tick();
    chk("pre_not_yet",  32'(bus.yellow), 32'd0);
    chk("pre_counts",   32'(bus.counts), 32'h0032);
    tick();
    chk("pre_yellow",   32'(bus.yellow), 32'd1);
    tick();
    bus.arrive = 4'b0;
    tick();
    chk("pre_select_gap", 32'({bus.green, bus.yellow}), 32'd0);
    tick();
    chk("pre_largest", 32'(bus.largest), 32'd1);
    chk("pre_green",   32'(bus.green),   32'd1);

    // Saturation on W, simultaneous arrive+depart, plain depart
    do_reset();
    bus.arrive = 4'b1000;
    repeat (20) tick();
    bus.arrive = 4'b0;
    chk("sat_counts", 32'(bus.counts), 32'hF000);
    chk("sat_yellow", 32'(bus.yellow), 32'd1);
    tick();
    tick();
    chk("sat_largest", 32'(bus.largest), 32'd3);
    chk("sat_green",   32'(bus.green),   32'd1);
    bus.arrive = 4'b1000;
    bus.depart = 1'b1;
    tick();
    chk("sat_arr_dep", 32'(bus.counts), 32'hF000);
    bus.arrive = 4'b0;
    tick();
    bus.depart = 1'b0;
    chk("sat_dep", 32'(bus.counts), 32'hE000);

    // Depart while IDLE and SELECT is ignored
    do_reset();
    bus.arrive = 4'b0100;
    tick();
    bus.arrive = 4'b0;
    bus.depart = 1'b1;
    tick();
    chk("idle_dep_counts", 32'(bus.counts), 32'h0100);
    tick();
    bus.depart = 1'b0;
    chk("sel_dep_counts", 32'(bus.counts), 32'h0100);
    chk("sel_dep_largest", 32'(bus.largest), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
